pipe_subtractor: RTL and testbench

PIPE_SUBTRACTOR -- requirements
Module: pipe_subtractor

---
 rtl/pipe_subtractor.sv | 107 ++++++++++
 tb/tb_pipe_subtractor.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_subtractor.sv
// pipe_subtractor: segmented ripple-borrow subtractor, one SEG-bit slice
// per stage, with skew/de-skew registers aligning each operation.
module pipe_subtractor #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);
    localparam int STAGES = WIDTH / SEG;

    logic adv;

    assign adv      = out_ready || !out_valid;
    assign in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int LO = k * SEG;
        localparam int HI = LO + SEG;

        logic [WIDTH-1:LO] a_in;
        logic [WIDTH-1:LO] b_in;
        logic              bi;
        logic              vi;
        logic [SEG:0]      sub;
        logic [HI-1:0]     d_nxt;
        logic              v_q;
        logic              br_q;
        logic [HI-1:0]     d_q;

        if (k == 0) begin : g_first
            assign a_in  = A;
            assign b_in  = B;
            assign bi    = bin;
            assign vi    = in_valid;
            assign d_nxt = sub[SEG-1:0];
        end else begin : g_next
            assign a_in  = g_st[k-1].g_skew.a_sk;
            assign b_in  = g_st[k-1].g_skew.b_sk;
            assign bi    = g_st[k-1].br_q;
            assign vi    = g_st[k-1].v_q;
            assign d_nxt = {sub[SEG-1:0], g_st[k-1].d_q};
        end

        // The borrow from the lower slice enters this slice's subtraction.
        assign sub = {1'b0, a_in[HI-1:LO]}
                   - {1'b0, b_in[HI-1:LO]}
                   - {{SEG{1'b0}}, bi};

        // Slice result, borrow and valid advance together, or all hold.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q  <= 1'b0;
                br_q <= 1'b0;
                d_q  <= '0;
            end else if (adv) begin
                v_q  <= vi;
                br_q <= sub[SEG];
                d_q  <= d_nxt;
            end
        end

        if (k < STAGES - 1) begin : g_skew
            logic [WIDTH-1:HI] a_sk;
            logic [WIDTH-1:HI] b_sk;

            // Operand slices not yet consumed wait here for later stages.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_sk <= '0;
                    b_sk <= '0;
                end else if (adv) begin
                    a_sk <= a_in[WIDTH-1:HI];
                    b_sk <= b_in[WIDTH-1:HI];
                end
            end
        end else begin : g_last
            logic ovf_q;

            // Signed overflow needs the operand sign bits seen only here.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (adv) begin
                    ovf_q <= (a_in[WIDTH-1] != b_in[WIDTH-1])
                          && (sub[SEG-1] != a_in[WIDTH-1]);
                end
            end
        end
    end

    assign out_valid = g_st[STAGES-1].v_q;
    assign diff      = g_st[STAGES-1].d_q;
    assign bout      = g_st[STAGES-1].br_q;
    assign ovf       = g_st[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_pipe_subtractor.sv
// tb_pipe_subtractor: directed and random traffic against a scoreboard
// built from plain integer arithmetic.
module tb_pipe_subtractor;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] A = '0;
    logic [15:0] B = '0;
    logic        bin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] diff;
    logic        bout;
    logic        ovf;

    always #5 clk = ~clk;

    pipe_subtractor #(.WIDTH(16), .SEG(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .A        (A),
        .B        (B),
        .bin      (bin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .diff     (diff),
        .bout     (bout),
        .ovf      (ovf)
    );

    typedef struct {
        logic [15:0] d;
        logic        bo;
        logic        ov;
        int          acc;
    } res_t;

    res_t        sb[$];
    res_t        last;
    int          total = 0;
    int          bad = 0;
    int          edges = 0;
    int          popped = 0;
    logic        lat_chk = 1'b0;
    logic        accepted = 1'b0;
    logic        hold_prev = 1'b0;
    logic [17:0] hold_val = '0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic res_t model(input logic [15:0] a,
                                   input logic [15:0] b,
                                   input logic c);
        res_t r;
        int   u;
        int   s;
        u    = int'(a) - int'(b) - int'(c);
        s    = int'($signed(a)) - int'($signed(b)) - int'(c);
        r.d  = u[15:0];
        r.bo = (u < 0);
        r.ov = (s < -32768) || (s > 32767);
        r.acc = 0;
        return r;
    endfunction

    task automatic cyc();
        res_t e;
        #1;
        chk("in_ready_rule", in_ready, out_ready || !out_valid);
        if (hold_prev)
            chk("hold", {out_valid, bout, ovf, diff}, {1'b1, hold_val});
        hold_prev = out_valid && !out_ready;
        hold_val  = {bout, ovf, diff};
        accepted  = in_valid && in_ready;
        if (out_valid && out_ready) begin
            total++;
            assert (sb.size() > 0) else begin
                bad++;
                $error("FAIL spurious_result got=%0h exp=none", diff);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("diff", diff, e.d);
                chk("bout", bout, e.bo);
                chk("ovf", ovf, e.ov);
                if (lat_chk) chk("latency", edges - e.acc, 3);
                last.d  = diff;
                last.bo = bout;
                last.ov = ovf;
                popped++;
            end
        end
        if (accepted) begin
            e = model(A, B, bin);
            e.acc = edges + 1;
            sb.push_back(e);
        end
        @(posedge clk);
        edges++;
        @(negedge clk);
    endtask

    task automatic single(input logic [15:0] a, input logic [15:0] b,
                          input logic c);
        int p0;
        int n;
        p0 = popped;
        n = 0;
        A = a;
        B = b;
        bin = c;
        in_valid = 1'b1;
        out_ready = 1'b1;
        lat_chk = 1'b1;
        cyc();
        in_valid = 1'b0;
        while (popped == p0 && n < 10) begin
            cyc();
            n++;
        end
        chk("single_done", popped - p0, 1);
        lat_chk = 1'b0;
    endtask

    initial begin
        int i;
        int n;
        int p0;
        int stall;
        int cnt;

        #2 rst = 1'b1;
        #1;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_diff", diff, 16'h0000);
        chk("rst_bout", bout, 1'b0);
        chk("rst_ovf", ovf, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("rel_in_ready", in_ready, 1'b1);
        @(negedge clk);

        single(16'h1234, 16'h0234, 1'b0);
        chk("r032", {last.d, last.bo, last.ov}, {16'h1000, 1'b0, 1'b0});
        single(16'h0000, 16'h0001, 1'b0);
        chk("r033", {last.d, last.bo, last.ov}, {16'hFFFF, 1'b1, 1'b0});
        single(16'h8000, 16'h0001, 1'b0);
        chk("r034a", {last.d, last.bo, last.ov}, {16'h7FFF, 1'b0, 1'b1});
        single(16'h0005, 16'h0005, 1'b1);
        chk("r034b", {last.d, last.bo, last.ov}, {16'hFFFF, 1'b1, 1'b0});

        i = 0;
        n = 0;
        p0 = popped;
        stall = -1;
        while ((i < 8 || popped - p0 < 8) && n < 100) begin
            out_ready = !(stall > 0);
            in_valid = (i < 8);
            A = 16'(i * 32'h1111);
            B = 16'h0101;
            bin = 1'b0;
            cyc();
            if (accepted) i++;
            if (stall > 0) begin
                chk("stall_in_ready", in_ready, 1'b0);
                chk("stall_valid", out_valid, 1'b1);
                stall--;
            end
            if (stall == -1 && out_valid) stall = 3;
            n++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("stall_count", popped - p0, 8);
        chk("stall_done", stall, 0);

        for (int j = 0; j < 3; j++) begin
            A = 16'($urandom);
            B = 16'($urandom);
            bin = 1'($urandom_range(0, 1));
            in_valid = 1'b1;
            cyc();
        end
        in_valid = 1'b0;
        cyc();
        chk("pre_rst_valid", out_valid, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_out", {diff, bout, ovf}, 18'h0);
        sb.delete();
        hold_prev = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1 chk("rel2_in_ready", in_ready, 1'b1);
        @(negedge clk);
        p0 = popped;
        for (int j = 0; j < 8; j++) cyc();
        chk("no_stale", popped - p0, 0);
        single(16'h00FF, 16'h0001, 1'b0);
        chk("r036", last.d, 16'h00FE);

        n = 0;
        cnt = 0;
        while (cnt < 10000 && n < 60000) begin
            in_valid = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            A = 16'($urandom);
            B = 16'($urandom);
            bin = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) A = {16{A[0]}};
            if ($urandom_range(0, 7) == 0) B = {B[15], 15'h0};
            cyc();
            if (accepted) cnt++;
            n++;
        end
        chk("rand_count", cnt, 10000);
        in_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (sb.size() > 0 && n < 20) begin
            cyc();
            n++;
        end
        chk("drain", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
